// File: rtl/mop_accum_ctrl_if.sv
// Operand/result handshake bundle for mop_accum_ctrl.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   start, op_count     job request and operand count (requester -> controller)
//   in_valid, in_data   operand stream (requester -> controller)
//   in_ready            operand accept (controller -> requester)
//   out_valid, out_sum  result (controller -> consumer)
//   out_ready           result consume (consumer -> controller)
//   busy                controller is not idle
// master = requester/consumer side, slave = controller side.
`timescale 1ns/1ps
interface mop_accum_ctrl_if #(
    parameter int WIDTH = 7,
    parameter int CNT_W = 4,
    parameter int OUT_W = 10
);
    logic             start;
    logic [CNT_W-1:0] op_count;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_sum;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, op_count, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  start, op_count, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/mop_accum_ctrl.sv
// Serial multi-operand adder: folds each operand into one carry-save stage, then resolves S/C to binary.
// Latency: 1 cycle per accepted operand, then RESOLVE of up to OUT_W+1 cycles (exactly 1 with MOP_FAST_CPA_EN).
// Backpressure: in_ready only in ACCUM (stalls on in_valid=0); result held in DONE until out_ready.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset; aborts any job, no partial result
//   s_if       slave side of mop_accum_ctrl_if (start/op_count, operand stream,
//              result stream, busy)
//
// Build option: define MOP_FAST_CPA_EN to resolve S+C with a single OUT_W-bit
// adder in one cycle; otherwise the iterative half-adder loop is used.
`timescale 1ns/1ps
module mop_accum_ctrl #(
    parameter int WIDTH   = 7,
    parameter int MAX_OPS = 8,
    parameter int CNT_W   = 4,
    parameter int OUT_W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    mop_accum_ctrl_if.slave s_if
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_OPS_C = CNT_W'(MAX_OPS);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           r_state;
    logic [OUT_W-1:0] r_s;
    logic [OUT_W-1:0] r_c;
    logic [CNT_W-1:0] r_rem;
    logic [OUT_W-1:0] r_sum;

    state_t           w_state_nxt;
    logic [OUT_W-1:0] w_s_nxt;
    logic [OUT_W-1:0] w_c_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [OUT_W-1:0] w_sum_nxt;

    // Operand zero-extended to the accumulator width.
    logic [OUT_W-1:0] w_x;
    // Majority of S, C and the operand: the carry bits before the shift.
    logic [OUT_W-1:0] w_maj;
    // Carry of the S/C half-add used by the iterative resolve loop.
    logic [OUT_W-1:0] w_hc;
    logic             w_accept;

    assign w_x      = {{(OUT_W-WIDTH){1'b0}}, s_if.in_data};
    assign w_maj    = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
    assign w_hc     = r_s & r_c;
    assign w_accept = (r_state == ST_ACCUM) && s_if.in_valid;

    // Next-state and datapath update; everything holds unless a branch says otherwise.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_c_nxt     = r_c;
        w_rem_nxt   = r_rem;
        w_sum_nxt   = r_sum;

        unique case (r_state)
            ST_IDLE: begin
                if (s_if.start) begin
                    w_s_nxt = '0;
                    w_c_nxt = '0;
                    if (s_if.op_count == '0) begin
                        // Empty job: S=C=0, so resolve yields 0 on its first cycle.
                        w_rem_nxt   = '0;
                        w_state_nxt = ST_RESOLVE;
                    end else begin
                        w_rem_nxt   = (s_if.op_count > MAX_OPS_C) ? MAX_OPS_C : s_if.op_count;
                        w_state_nxt = ST_ACCUM;
                    end
                end
            end

            ST_ACCUM: begin
                if (w_accept) begin
                    w_s_nxt   = r_s ^ r_c ^ w_x;
                    // The top majority bit is dropped: OUT_W is sized so the
                    // true sum never needs it.
                    w_c_nxt   = {w_maj[OUT_W-2:0], 1'b0};
                    w_rem_nxt = r_rem - ONE_C;
                    // r_rem is never 0 while in ACCUM, so 1 means this is the last operand.
                    if (r_rem == ONE_C) begin
                        w_state_nxt = ST_RESOLVE;
                    end
                end
            end

            ST_RESOLVE: begin
`ifdef MOP_FAST_CPA_EN
                w_sum_nxt   = r_s + r_c;
                w_state_nxt = ST_DONE;
`else
                // Each pass is a half-add of S and C; the lowest set carry bit
                // moves up at least one position, so C drains within OUT_W passes.
                if (r_c == '0) begin
                    w_sum_nxt   = r_s;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_s_nxt = r_s ^ r_c;
                    w_c_nxt = {w_hc[OUT_W-2:0], 1'b0};
                end
`endif
            end

            ST_DONE: begin
                if (s_if.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_c     <= '0;
            r_rem   <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_c     <= w_c_nxt;
            r_rem   <= w_rem_nxt;
            r_sum   <= w_sum_nxt;
        end
    end

    // Handshake outputs come straight from the state register, never from inputs.
    assign s_if.in_ready  = (r_state == ST_ACCUM);
    assign s_if.out_valid = (r_state == ST_DONE);
    assign s_if.busy      = (r_state != ST_IDLE);
    assign s_if.out_sum   = r_sum;

endmodule

// File: tb/tb_mop_accum_ctrl.sv
`timescale 1ns/1ps
module tb_mop_accum_ctrl;

    localparam int WIDTH   = 7;
    localparam int MAX_OPS = 8;
    localparam int CNT_W   = 4;
    localparam int OUT_W   = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mop_accum_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .OUT_W(OUT_W)) bus ();

    mop_accum_ctrl #(
        .WIDTH  (WIDTH),
        .MAX_OPS(MAX_OPS),
        .CNT_W  (CNT_W),
        .OUT_W  (OUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .s_if(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] ops [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) ops[i] = WIDTH'($urandom);
    endtask

    // One complete job. Reference: the result is the plain sum of the first
    // min(cnt, MAX_OPS) operands offered; no more than that may be accepted.
    task automatic run_job(input int cnt, input int gap_pct, input int hold, input bit pulses);
        int n, k, cyc, last_edge, lat, rdy_late;
        logic [31:0] exp_sum;
        logic [OUT_W-1:0] held;
        bit stable;

        n = (cnt > MAX_OPS) ? MAX_OPS : cnt;
        exp_sum = 0;
        for (int i = 0; i < n; i++) exp_sum += 32'(ops[i]);

        chk("idle_busy", 32'(bus.busy), 32'd0);
        bus.start    = 1'b1;
        bus.op_count = CNT_W'(cnt);
        step();
        bus.start = 1'b0;
        chk("started_busy", 32'(bus.busy), 32'd1);

        k = 0; cyc = 0; last_edge = 0; rdy_late = 0;
        while (!bus.out_valid && cyc < 200) begin
            bus.in_valid = (int'($urandom_range(99)) >= gap_pct);
            bus.in_data  = (k < 16) ? ops[k] : WIDTH'($urandom);
            if (pulses) begin
                bus.start    = ($urandom_range(3) == 0);
                bus.op_count = CNT_W'($urandom);
            end
            if (bus.in_ready && k >= n) rdy_late++;
            if (bus.in_valid && bus.in_ready) begin
                k++;
                if (k == n) last_edge = cyc + 1;
            end
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        lat = cyc - last_edge;

        chk("done_reached", 32'(bus.out_valid), 32'd1);
        if (!bus.out_valid) begin
            reset_dut();
            return;
        end
        chk("accepts", 32'(k), 32'(n));
        chk("late_in_ready", 32'(rdy_late), 32'd0);
`ifdef MOP_FAST_CPA_EN
        chk("resolve_latency", 32'(lat), 32'd1);
`else
        chk("resolve_latency_bound", 32'(lat >= 1 && lat <= OUT_W + 1), 32'd1);
`endif
        chk("sum", 32'(bus.out_sum), exp_sum);
        chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);

        held   = bus.out_sum;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.out_ready = 1'b0;
            if (pulses) begin
                bus.start    = ($urandom_range(1) == 0);
                bus.op_count = CNT_W'($urandom);
            end
            step();
            if (!bus.out_valid || bus.out_sum !== held) stable = 1'b0;
        end
        bus.start = 1'b0;
        chk("hold_stable", 32'(stable), 32'd1);

        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("valid_dropped", 32'(bus.out_valid), 32'd0);
        chk("back_to_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.op_count  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic: 1+2+3
        ops[0] = 7'd1; ops[1] = 7'd2; ops[2] = 7'd3;
        run_job(3, 0, 5, 1'b0);

        // Worst case: eight operands of 127
        for (int i = 0; i < 16; i++) ops[i] = 7'h7F;
        run_job(8, 0, 2, 1'b0);

        // Empty job and clamped job
        fill_random();
        run_job(0, 0, 1, 1'b0);
        fill_random();
        run_job(12, 0, 1, 1'b0);

        // Stalls, long back-pressure, start pulses while busy
        fill_random();
        run_job(6, 40, 20, 1'b1);

        // Reset mid-job after 2 of 5 operands
        fill_random();
        bus.start    = 1'b1;
        bus.op_count = CNT_W'(5);
        step();
        bus.start = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ops[k];
            if (bus.in_ready) k++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_out_sum", 32'(bus.out_sum), 32'd0);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 16; i++) ops[i] = 7'd5;
        run_job(4, 0, 0, 1'b0);

        // Random regression
        for (int j = 0; j < 1000; j++) begin
            fill_random();
            run_job(int'($urandom_range(15)), int'($urandom_range(30)),
                    int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
